// File: rtl/block_column_sched.sv
// block_column_sched: board scheduler for a 4-column x 8-row falling-block game.
// Holds the board, steps it down one row per game tick, spawns blocks from an LFSR
// and resolves player key hits against the bottom row.
//
// Ports:
//   CLK_50M           system clock
//   RST               asynchronous active-high reset
//   start             one-cycle pulse: clear board/score/miss and begin play
//   key[3:0]          one-cycle hit pulses, bit k = column k
//   column_0..3[23:0] board columns, row 0 (top) in [23:21], row 7 (bottom) in [2:0]
//   score[7:0]        hit count, saturating at 255
//   miss[3:0]         miss count (wrong key or fall-off), saturating at 15
//   game_over         high while in the OVER state
//   step_pulse        one-cycle strobe after each board step
module block_column_sched #(
    parameter int unsigned TICK_DIV  = 25_000_000,
    parameter int unsigned MAX_MISS  = 8,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic        CLK_50M,
    input  logic        RST,
    input  logic        start,
    input  logic [3:0]  key,
    output logic [23:0] column_0,
    output logic [23:0] column_1,
    output logic [23:0] column_2,
    output logic [23:0] column_3,
    output logic [7:0]  score,
    output logic [3:0]  miss,
    output logic        game_over,
    output logic        step_pulse
);

    localparam int unsigned CntW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 2;
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);
    localparam logic [3:0] MaxMiss = 4'(MAX_MISS);

    typedef enum logic [1:0] {StIdle, StRun, StOver} state_e;

    state_e            state_q, state_d;
    logic [23:0]       cols_q [4];
    logic [23:0]       cols_d [4];
    logic [7:0]        score_q, score_d;
    logic [3:0]        miss_q, miss_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [7:0]        lfsr_q, lfsr_d;
    logic              step_pulse_q, step_pulse_d;
    logic              game_over_q, game_over_d;

    logic              run_active;
    logic              step;
    logic              spawn;
    logic [1:0]        target;
    logic [2:0]        colour;
    logic              feedback;
    logic [3:0]        hit, wrong, fall;
    logic [23:0]       col_next [4];
    logic [8:0]        score_sum;
    logic [4:0]        miss_sum;

    // Play only advances in RUN below the miss limit; start takes priority over everything.
    assign run_active = (state_q == StRun) && (miss_q < MaxMiss) && !start;
    assign step       = run_active && (cnt_q == CntMax);

    // Spawn decision is taken from the pre-advance LFSR value.
    always_comb begin
        spawn    = lfsr_q[7:6] != 2'b00;
        target   = lfsr_q[1:0];
        colour   = (lfsr_q[4:2] == 3'b000) ? 3'b100 : lfsr_q[4:2];
        feedback = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    end

    // Per-column hit resolution against the pre-shift bottom cell, then the optional shift.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            logic        bottom_nz;
            logic [23:0] cleared;
            logic [2:0]  top;
            bottom_nz = cols_q[k][2:0] != 3'b000;
            hit[k]    = run_active && key[k] && bottom_nz;
            wrong[k]  = run_active && key[k] && !bottom_nz;
            fall[k]   = step && bottom_nz && !key[k];
            cleared   = hit[k] ? {cols_q[k][23:3], 3'b000} : cols_q[k];
            top       = (spawn && (target == 2'(k))) ? colour : 3'b000;
            col_next[k] = step ? {top, cleared[23:3]} : cleared;
        end
    end

    // Increments are summed first, then saturated once.
    assign score_sum = {1'b0, score_q} + 9'($countones(hit));
    assign miss_sum  = {1'b0, miss_q} + 5'($countones(wrong)) + 5'($countones(fall));

    always_comb begin
        state_d      = state_q;
        cols_d       = cols_q;
        score_d      = score_q;
        miss_d       = miss_q;
        cnt_d        = cnt_q;
        lfsr_d       = lfsr_q;
        step_pulse_d = 1'b0;
        if (start) begin
            state_d = StRun;
            for (int k = 0; k < 4; k++) cols_d[k] = '0;
            score_d = '0;
            miss_d  = '0;
            cnt_d   = '0;
            lfsr_d  = LFSR_SEED;
        end else if (state_q == StRun) begin
            if (miss_q >= MaxMiss) begin
                state_d = StOver;
            end else begin
                cols_d       = col_next;
                cnt_d        = step ? '0 : cnt_q + 1'b1;
                lfsr_d       = step ? {lfsr_q[6:0], feedback} : lfsr_q;
                step_pulse_d = step;
                score_d      = (score_sum > 9'd255) ? 8'd255 : score_sum[7:0];
                miss_d       = (miss_sum > 5'd15) ? 4'd15 : miss_sum[3:0];
            end
        end
        game_over_d = (state_d == StOver);
    end

    always_ff @(posedge CLK_50M or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            for (int k = 0; k < 4; k++) cols_q[k] <= '0;
            score_q      <= '0;
            miss_q       <= '0;
            cnt_q        <= '0;
            lfsr_q       <= LFSR_SEED;
            step_pulse_q <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            for (int k = 0; k < 4; k++) cols_q[k] <= cols_d[k];
            score_q      <= score_d;
            miss_q       <= miss_d;
            cnt_q        <= cnt_d;
            lfsr_q       <= lfsr_d;
            step_pulse_q <= step_pulse_d;
            game_over_q  <= game_over_d;
        end
    end

    assign column_0   = cols_q[0];
    assign column_1   = cols_q[1];
    assign column_2   = cols_q[2];
    assign column_3   = cols_q[3];
    assign score      = score_q;
    assign miss       = miss_q;
    assign game_over  = game_over_q;
    assign step_pulse = step_pulse_q;

endmodule

// File: tb/tb_block_column_sched.sv
// Bench for block_column_sched: table-driven vectors on a long-miss-limit instance,
// plus hand-written sequences for reset and game-over on a MAX_MISS=2 instance.
module tb_block_column_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start2;
    logic [3:0]  key, key2;
    logic [23:0] c0, c1, c2, c3;
    logic [23:0] d0, d1, d2, d3;
    logic [7:0]  sc, sc2;
    logic [3:0]  ms, ms2;
    logic        go, go2, sp, sp2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    block_column_sched #(.TICK_DIV(4), .MAX_MISS(15), .LFSR_SEED(8'hA5)) dut (
        .CLK_50M(clk), .RST(rst), .start(start), .key(key),
        .column_0(c0), .column_1(c1), .column_2(c2), .column_3(c3),
        .score(sc), .miss(ms), .game_over(go), .step_pulse(sp)
    );

    block_column_sched #(.TICK_DIV(4), .MAX_MISS(2), .LFSR_SEED(8'hA5)) dut2 (
        .CLK_50M(clk), .RST(rst), .start(start2), .key(key2),
        .column_0(d0), .column_1(d1), .column_2(d2), .column_3(d3),
        .score(sc2), .miss(ms2), .game_over(go2), .step_pulse(sp2)
    );

    typedef struct {
        logic        st;
        logic [3:0]  k;
        int          n;
        logic [23:0] e0, e1, e2, e3;
        logic [7:0]  esc;
        logic [3:0]  ems;
        logic        esp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic [3:0] k, input int n,
                                input logic [23:0] e0, input logic [23:0] e1,
                                input logic [23:0] e2, input logic [23:0] e3,
                                input logic [7:0] esc, input logic [3:0] ems, input logic esp);
        vec_t v;
        v.st = st; v.k = k; v.n = n;
        v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3;
        v.esc = esc; v.ems = ems; v.esp = esp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit sp_seen;
        // Hand-computed board evolution for seed A5, TICK_DIV=4 (LFSR A5,4A,95,2A,54,A9,53,
        // A7,4E,9D,3B,77,EE,DD,BB).
        vecs.push_back(mk(1, 4'h0, 1, 0, 0, 0, 0, 0, 0, 0));                        // start
        vecs.push_back(mk(0, 4'h0, 4, 0, 24'h200000, 0, 0, 0, 0, 1));               // step 1
        vecs.push_back(mk(0, 4'h0, 1, 0, 24'h200000, 0, 0, 0, 0, 0));               // pulse ends
        vecs.push_back(mk(0, 4'h0, 3, 0, 24'h040000, 24'h400000, 0, 0, 0, 1));      // step 2
        vecs.push_back(mk(0, 4'h1, 1, 0, 24'h040000, 24'h400000, 0, 0, 1, 0));      // wrong key
        vecs.push_back(mk(0, 4'h0, 3, 0, 24'hA08000, 24'h080000, 0, 0, 1, 1));      // step 3
        vecs.push_back(mk(0, 4'h0, 4, 0, 24'h141000, 24'h010000, 0, 0, 1, 1));      // step 4
        vecs.push_back(mk(0, 4'h0, 4, 24'hA00000, 24'h028200, 24'h002000, 0, 0, 1, 1));
        vecs.push_back(mk(0, 4'h0, 4, 24'h140000, 24'h405040, 24'h000400, 0, 0, 1, 1));
        vecs.push_back(mk(0, 4'h0, 4, 24'h028000, 24'h080A08, 24'h000080, 24'h800000, 0, 1, 1));
        vecs.push_back(mk(0, 4'h0, 4, 24'h005000, 24'h010141, 24'h000010, 24'h300000, 0, 1, 1));
        vecs.push_back(mk(0, 4'h2, 1, 24'h005000, 24'h010140, 24'h000010, 24'h300000, 1, 1, 0));
        vecs.push_back(mk(0, 4'h0, 3, 24'h000A00, 24'h002028, 24'h600002, 24'h060000, 1, 1, 1));
        vecs.push_back(mk(0, 4'h4, 1, 24'h000A00, 24'h002028, 24'h600000, 24'h060000, 2, 1, 0));
        vecs.push_back(mk(0, 4'h0, 3, 24'h000140, 24'hE00405, 24'h0C0000, 24'h00C000, 2, 1, 1));
        vecs.push_back(mk(0, 4'h0, 4, 24'h000028, 24'h1C0080, 24'h018000, 24'h001800, 2, 2, 1));
        vecs.push_back(mk(0, 4'h0, 4, 24'h000005, 24'h038010, 24'h003000, 24'hA00300, 2, 2, 1));
        vecs.push_back(mk(0, 4'h1, 4, 0, 24'h007002, 24'h600600, 24'h140060, 3, 2, 1));
        vecs.push_back(mk(0, 4'h0, 4, 0, 24'hE00E00, 24'h0C00C0, 24'h02800C, 3, 3, 1));
        vecs.push_back(mk(0, 4'h8, 4, 0, 24'h1C01C0, 24'h018018, 24'hC05001, 4, 3, 1));
        vecs.push_back(mk(0, 4'hF, 1, 0, 24'h1C01C0, 24'h018018, 24'hC05000, 5, 6, 0));
        vecs.push_back(mk(1, 4'h0, 1, 0, 0, 0, 0, 0, 0, 0));                        // restart
        vecs.push_back(mk(0, 4'hF, 1, 0, 0, 0, 0, 0, 4, 0));                        // 4 misses
        vecs.push_back(mk(0, 4'h0, 3, 0, 24'h200000, 0, 0, 0, 4, 1));               // reseeded

        rst = 1'b1; start = 1'b0; key = 4'h0; start2 = 1'b0; key2 = 4'h0;
        tick(); tick();
        chk("reset col0", 32'(c0), 0);
        chk("reset col1", 32'(c1), 0);
        chk("reset score", 32'(sc), 0);
        chk("reset miss", 32'(ms), 0);
        chk("reset game_over", 32'(go), 0);
        chk("reset step_pulse", 32'(sp), 0);
        rst = 1'b0;

        // Keys in IDLE are ignored.
        key = 4'hF; tick(); key = 4'h0;
        chk("idle key miss", 32'(ms), 0);
        chk("idle key score", 32'(sc), 0);

        foreach (vecs[i]) begin
            for (int j = 0; j < vecs[i].n; j++) begin
                start = (j == vecs[i].n - 1) ? vecs[i].st : 1'b0;
                key   = (j == vecs[i].n - 1) ? vecs[i].k : 4'h0;
                tick();
            end
            start = 1'b0; key = 4'h0;
            chk($sformatf("v%0d col0", i), 32'(c0), 32'(vecs[i].e0));
            chk($sformatf("v%0d col1", i), 32'(c1), 32'(vecs[i].e1));
            chk($sformatf("v%0d col2", i), 32'(c2), 32'(vecs[i].e2));
            chk($sformatf("v%0d col3", i), 32'(c3), 32'(vecs[i].e3));
            chk($sformatf("v%0d score", i), 32'(sc), 32'(vecs[i].esc));
            chk($sformatf("v%0d miss", i), 32'(ms), 32'(vecs[i].ems));
            chk($sformatf("v%0d step_pulse", i), 32'(sp), 32'(vecs[i].esp));
            chk($sformatf("v%0d game_over", i), 32'(go), 0);
        end

        // Asynchronous reset mid-RUN, in the middle of a step_pulse cycle.
        #3 rst = 1'b1;
        #1;
        chk("async rst col1", 32'(c1), 0);
        chk("async rst miss", 32'(ms), 0);
        chk("async rst step_pulse", 32'(sp), 0);
        chk("async rst game_over", 32'(go), 0);
        tick();
        rst = 1'b0;
        sp_seen = 1'b0;
        for (int j = 0; j < 8; j++) begin
            tick();
            if (sp) sp_seen = 1'b1;
        end
        chk("idle after rst no step", 32'(sp_seen), 0);
        chk("idle after rst col1", 32'(c1), 0);

        // Game over on the MAX_MISS=2 instance.
        start2 = 1'b1; tick(); start2 = 1'b0;
        tick(); tick(); tick(); tick();
        chk("go step1 col1", 32'(d1), 32'h200000);
        chk("go step1 pulse", 32'(sp2), 1);
        key2 = 4'h1; tick(); key2 = 4'h0;
        chk("go miss1", 32'(ms2), 1);
        key2 = 4'h1; tick(); key2 = 4'h0;
        chk("go miss2", 32'(ms2), 2);
        chk("go not yet over", 32'(go2), 0);
        tick();
        chk("go over", 32'(go2), 1);
        sp_seen = 1'b0;
        for (int j = 0; j < 12; j++) begin
            key2 = 4'h1;
            tick();
            if (sp2) sp_seen = 1'b1;
        end
        key2 = 4'h0;
        chk("over no step", 32'(sp_seen), 0);
        chk("over frozen col1", 32'(d1), 32'h200000);
        chk("over frozen col2", 32'(d2), 0);
        chk("over key ignored", 32'(ms2), 2);
        chk("over score", 32'(sc2), 0);
        chk("over held", 32'(go2), 1);
        start2 = 1'b1; tick(); start2 = 1'b0;
        chk("restart game_over", 32'(go2), 0);
        chk("restart miss", 32'(ms2), 0);
        chk("restart col1", 32'(d1), 0);
        tick(); tick(); tick(); tick();
        chk("restart reseed col1", 32'(d1), 32'h200000);
        chk("restart reseed col2", 32'(d2), 0);
        chk("restart step_pulse", 32'(sp2), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
